// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift sequencer: FSM states,
// shift-register control codes, mux select codes and supported funct values.
package shift_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WB    = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Shift register control codes
    localparam logic [2:0] SH_HOLD = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;

    // Shift source mux selects
    localparam logic [1:0] SRC_B   = 2'b00;
    localparam logic [1:0] SRC_A   = 2'b01;
    localparam logic [1:0] SRC_IMM = 2'b10;

    // Shift amount mux selects
    localparam logic [1:0] AMT_SHAMT = 2'b00;
    localparam logic [1:0] AMT_RS    = 2'b01;
    localparam logic [1:0] AMT_LUI   = 2'b10;

    // Supported R-type shift funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;

endpackage

// File: rtl/shift_funct_decode.sv
// Combinational decode of a shift request (funct + is_lui) into the
// source select, amount select, shift operation and a legality flag.
module shift_funct_decode
    import shift_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic       is_lui,
    output logic [1:0] src_sel,
    output logic [1:0] amt_sel,
    output logic [2:0] op,
    output logic       legal
);

    // LUI overrides funct; anything else outside the shift set is illegal
    always_comb begin
        src_sel = SRC_B;
        amt_sel = AMT_SHAMT;
        op      = SH_HOLD;
        legal   = 1'b1;
        if (is_lui) begin
            src_sel = SRC_IMM;
            amt_sel = AMT_LUI;
            op      = SH_SLL;
        end else begin
            case (funct)
                F_SLL:   op = SH_SLL;
                F_SRL:   op = SH_SRL;
                F_SRA:   op = SH_SRA;
                F_SLLV: begin op = SH_SLL; amt_sel = AMT_RS; end
                F_SRLV: begin op = SH_SRL; amt_sel = AMT_RS; end
                F_SRAV: begin op = SH_SRA; amt_sel = AMT_RS; end
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multicycle sequencer for the shift datapath: accepts one shift request,
// steps the shift register through LOAD -> SHIFT -> WB and pulses done.
// Optional macro SHIFT_ZERO_SKIP_EN: a zero effective shift amount skips
// the SHIFT state (LOAD goes straight to WB).
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int AMT_W   = 5,
    parameter int LUI_AMT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic             is_lui,
    input  logic [AMT_W-1:0] shamt,
    input  logic [AMT_W-1:0] rs_amt,
    output logic [1:0]       shift_src_sel,
    output logic [1:0]       shift_amt_sel,
    output logic [2:0]       shift_op,
    output logic             write_rd,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

`ifdef SHIFT_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [1:0]       src_q, src_d;
    logic [1:0]       amt_q, amt_d;
    logic [2:0]       op_q, op_d;
    logic             zero_q, zero_d;

    logic [1:0]       dec_src;
    logic [1:0]       dec_amt;
    logic [2:0]       dec_op;
    logic             dec_legal;
    logic [AMT_W-1:0] eff_amt;

    shift_funct_decode u_decode (
        .funct   (funct),
        .is_lui  (is_lui),
        .src_sel (dec_src),
        .amt_sel (dec_amt),
        .op      (dec_op),
        .legal   (dec_legal)
    );

    // Amount the datapath would actually shift by for the incoming request
    always_comb begin
        case (dec_amt)
            AMT_RS:  eff_amt = rs_amt;
            AMT_LUI: eff_amt = AMT_W'(LUI_AMT);
            default: eff_amt = shamt;
        endcase
    end

    // Next-state logic; decoded request is captured only on accept in IDLE
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        amt_d   = amt_q;
        op_d    = op_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = dec_src;
                    amt_d   = dec_amt;
                    op_d    = dec_op;
                    zero_d  = (eff_amt == '0) && !is_lui;
                    state_d = dec_legal ? ST_LOAD : ST_ERR;
                end
            end
            ST_LOAD:  state_d = (ZERO_SKIP && zero_q) ? ST_WB : ST_SHIFT;
            ST_SHIFT: state_d = ST_WB;
            ST_WB:    state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched request registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= SRC_B;
            amt_q   <= AMT_SHAMT;
            op_q    <= SH_HOLD;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
        end
    end

    // Moore output decode from state plus latched request
    always_comb begin
        shift_src_sel = SRC_B;
        shift_amt_sel = AMT_SHAMT;
        shift_op      = SH_HOLD;
        write_rd      = 1'b0;
        done          = 1'b0;
        illegal       = 1'b0;
        busy          = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD: begin
                shift_src_sel = src_q;
                shift_amt_sel = amt_q;
                shift_op      = SH_LOAD;
            end
            ST_SHIFT: begin
                shift_src_sel = src_q;
                shift_amt_sel = amt_q;
                shift_op      = op_q;
            end
            ST_WB: begin
                write_rd = 1'b1;
                done     = 1'b1;
            end
            ST_ERR: begin
                done    = 1'b1;
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: stimulus pushes expected transactions,
// a negedge monitor reconstructs each transaction and compares on done/abort.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] funct;
    logic       is_lui;
    logic [4:0] shamt;
    logic [4:0] rs_amt;
    logic [1:0] shift_src_sel;
    logic [1:0] shift_amt_sel;
    logic [2:0] shift_op;
    logic       write_rd;
    logic       busy;
    logic       done;
    logic       illegal;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.AMT_W(5), .LUI_AMT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .funct         (funct),
        .is_lui        (is_lui),
        .shamt         (shamt),
        .rs_amt        (rs_amt),
        .shift_src_sel (shift_src_sel),
        .shift_amt_sel (shift_amt_sel),
        .shift_op      (shift_op),
        .write_rd      (write_rd),
        .busy          (busy),
        .done          (done),
        .illegal       (illegal)
    );

`ifdef SHIFT_ZERO_SKIP_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 3;
`endif

    typedef struct {
        string      tag;
        logic [1:0] src;
        logic [1:0] amt;
        logic [2:0] op;
        logic       ill;
        int         lat;
        logic       abort;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endfunction

    function automatic exp_t mk(input string tag, input logic [1:0] src, input logic [1:0] amt,
                                input logic [2:0] op, input logic ill, input int lat,
                                input logic abort);
        exp_t e;
        e.tag = tag; e.src = src; e.amt = amt; e.op = op;
        e.ill = ill; e.lat = lat; e.abort = abort;
        return e;
    endfunction

    // ---------------- monitor ----------------
    int         k = 0;
    logic [1:0] ld_src, ld_amt, sh_src, sh_amt;
    logic [2:0] ld_op, sh_op;
    exp_t       cur;

    task close_txn(input bit aborted);
        if (expq.size() == 0) begin
            check("unexpected_txn", 1, 0);
            return;
        end
        cur = expq.pop_front();
        check({cur.tag, "_abort"}, int'(aborted), int'(cur.abort));
        if (aborted || cur.abort) return;
        check({cur.tag, "_latency"}, k, cur.lat);
        check({cur.tag, "_illegal"}, int'(illegal), int'(cur.ill));
        check({cur.tag, "_write_rd"}, int'(write_rd), int'(!cur.ill));
        check({cur.tag, "_done_op"}, int'(shift_op), 0);
        check({cur.tag, "_done_sel"}, int'({shift_src_sel, shift_amt_sel}), 0);
        if (!cur.ill) begin
            check({cur.tag, "_load_op"}, int'(ld_op), 1);
            check({cur.tag, "_load_src"}, int'(ld_src), int'(cur.src));
            check({cur.tag, "_load_amt"}, int'(ld_amt), int'(cur.amt));
            if (cur.lat == 3) begin
                check({cur.tag, "_shift_op"}, int'(sh_op), int'(cur.op));
                check({cur.tag, "_shift_src"}, int'(sh_src), int'(cur.src));
                check({cur.tag, "_shift_amt"}, int'(sh_amt), int'(cur.amt));
            end
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            k++;
            if (k == 1) begin
                ld_op = shift_op; ld_src = shift_src_sel; ld_amt = shift_amt_sel;
            end else if (k == 2) begin
                sh_op = shift_op; sh_src = shift_src_sel; sh_amt = shift_amt_sel;
            end
            if (done) begin
                close_txn(1'b0);
                k = 0;
            end else if (k > 4) begin
                check("txn_too_long", k, 3);
                if (expq.size() != 0) cur = expq.pop_front();
                k = 0;
            end
        end else begin
            if (k != 0) begin
                close_txn(1'b1);
                k = 0;
            end
            if (!reset)
                check("idle_quiet", int'({done, write_rd, illegal, shift_op,
                                          shift_src_sel, shift_amt_sel}), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input exp_t e, input logic [5:0] f, input logic lui,
                         input logic [4:0] sa, input logic [4:0] rs);
        expq.push_back(e);
        start = 1'b1; funct = f; is_lui = lui; shamt = sa; rs_amt = rs;
        step();
        start = 1'b0; funct = 6'h3F; shamt = 5'd0; rs_amt = 5'd0; is_lui = 1'b0;
        step(); step(); step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'h00; is_lui = 1'b0;
        shamt = 5'd0; rs_amt = 5'd0;
        step(); step();
        check("reset_outputs", int'({busy, done, write_rd, illegal, shift_op,
                                     shift_src_sel, shift_amt_sel}), 0);
        reset = 1'b0;
        step();

        issue(mk("sll3",  2'b00, 2'b00, 3'b010, 1'b0, 3, 1'b0), 6'h00, 1'b0, 5'd3,  5'd0);
        issue(mk("srav",  2'b00, 2'b01, 3'b100, 1'b0, 3, 1'b0), 6'h07, 1'b0, 5'd0,  5'd31);
        issue(mk("lui",   2'b10, 2'b10, 3'b010, 1'b0, 3, 1'b0), 6'h2A, 1'b1, 5'd0,  5'd0);
        issue(mk("add",   2'b00, 2'b00, 3'b000, 1'b1, 1, 1'b0), 6'h20, 1'b0, 5'd4,  5'd4);
        issue(mk("srl7",  2'b00, 2'b00, 3'b011, 1'b0, 3, 1'b0), 6'h02, 1'b0, 5'd7,  5'd1);
        issue(mk("sllv",  2'b00, 2'b01, 3'b010, 1'b0, 3, 1'b0), 6'h04, 1'b0, 5'd0,  5'd9);
        issue(mk("srlv",  2'b00, 2'b01, 3'b011, 1'b0, 3, 1'b0), 6'h06, 1'b0, 5'd2,  5'd1);
        issue(mk("sra31", 2'b00, 2'b00, 3'b100, 1'b0, 3, 1'b0), 6'h03, 1'b0, 5'd31, 5'd0);
        issue(mk("func01",2'b00, 2'b00, 3'b000, 1'b1, 1, 1'b0), 6'h01, 1'b0, 5'd3,  5'd3);

        // start held high: accepts at edges 0, 4 and 8 only; funct wiggles mid-flight
        expq.push_back(mk("hold0", 2'b00, 2'b00, 3'b011, 1'b0, 3, 1'b0));
        expq.push_back(mk("hold1", 2'b00, 2'b00, 3'b011, 1'b0, 3, 1'b0));
        expq.push_back(mk("hold2", 2'b00, 2'b00, 3'b011, 1'b0, 3, 1'b0));
        start = 1'b1; funct = 6'h02; shamt = 5'd4; rs_amt = 5'd6;
        step();                               // edge 0: accept
        funct = 6'h07; is_lui = 1'b1;
        step(); step();
        funct = 6'h02; is_lui = 1'b0;
        step();                               // edge 3: WB, start ignored
        step();                               // edge 4: accept
        funct = 6'h06;
        step(); step();
        funct = 6'h02;
        step();
        step();                               // edge 8: accept
        funct = 6'h20;
        step();
        start = 1'b0;
        step(); step(); step();

        // reset while in SHIFT aborts without done/write_rd
        expq.push_back(mk("rst_mid", 2'b00, 2'b00, 3'b010, 1'b0, 0, 1'b1));
        start = 1'b1; funct = 6'h00; shamt = 5'd5;
        step();                               // accept -> LOAD
        start = 1'b0;
        step();                               // -> SHIFT
        reset = 1'b1;
        step();                               // -> IDLE
        reset = 1'b0;
        check("rst_mid_outputs", int'({busy, done, write_rd, illegal, shift_op,
                                       shift_src_sel, shift_amt_sel}), 0);
        step(); step();

        // zero-amount cases: effective amount picks shamt or rs_amt, never LUI
        issue(mk("sll0",    2'b00, 2'b00, 3'b010, 1'b0, ZLAT, 1'b0), 6'h00, 1'b0, 5'd0, 5'd7);
        issue(mk("sllv_rs0",2'b00, 2'b01, 3'b010, 1'b0, ZLAT, 1'b0), 6'h04, 1'b0, 5'd3, 5'd0);
        issue(mk("sllv_rs4",2'b00, 2'b01, 3'b010, 1'b0, 3,    1'b0), 6'h04, 1'b0, 5'd0, 5'd4);
        issue(mk("lui_z",   2'b10, 2'b10, 3'b010, 1'b0, 3,    1'b0), 6'h00, 1'b1, 5'd0, 5'd0);

        for (int i = 0; i < 50 && expq.size() != 0; i++) step();
        if (expq.size() != 0) check("drain", expq.size(), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
